// File: rtl/piso_pkg.sv
// Shared types and helpers for the parametrised PISO shift register.
package piso_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } piso_state_e;

    function automatic int unsigned cnt_width(input int unsigned width);
        return $clog2(width);
    endfunction

endpackage

// File: rtl/piso_bit_counter.sv
// Loadable down-counter that saturates at zero; tracks bits left in a frame.
module piso_bit_counter
    import piso_pkg::*;
#(
    parameter int unsigned CW = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load,
    input  logic [CW-1:0] load_val,
    input  logic          dec,
    output logic          zero
);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (dec && (cnt_q != '0)) begin
            cnt_d = cnt_q - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero = (cnt_q == '0);

endmodule

// File: rtl/piso_shift_reg_param.sv
// Parallel-in/serial-out shift register with valid/ready load, bit-rate
// enable, selectable bit order and a frame-done pulse.
module piso_shift_reg_param
    import piso_pkg::*;
#(
    parameter int unsigned WIDTH     = 8,
    parameter bit          MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic [WIDTH-1:0] din,
    input  logic             shift_en,
    output logic             sout,
    output logic             sout_valid,
    output logic             busy,
    output logic             done
);

    localparam int unsigned    CW   = cnt_width(WIDTH);
    localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

    piso_state_e      state_q, state_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [WIDTH-1:0] shreg_shifted;
    logic             cnt_zero;
    logic             accept;
    logic             in_shift;

    assign in_shift   = (state_q == SHIFT);
    assign done       = in_shift && cnt_zero && shift_en;
    assign load_ready = (state_q == IDLE) || done;
    assign accept     = load_valid && load_ready;

    assign shreg_shifted = MSB_FIRST ? {shreg_q[WIDTH-2:0], 1'b0}
                                     : {1'b0, shreg_q[WIDTH-1:1]};

    piso_bit_counter #(
        .CW(CW)
    ) u_bit_counter (
        .clk      (clk),
        .rst      (rst),
        .load     (accept),
        .load_val (LAST),
        .dec      (in_shift && shift_en),
        .zero     (cnt_zero)
    );

    // Clearing the register on the final bit keeps sout a plain flop tap
    // that reads 0 whenever the block is idle.
    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        if (accept) begin
            shreg_d = din;
            state_d = SHIFT;
        end else if (in_shift && shift_en) begin
            if (cnt_zero) begin
                shreg_d = '0;
                state_d = IDLE;
            end else begin
                shreg_d = shreg_shifted;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            shreg_q <= '0;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
        end
    end

    assign sout       = MSB_FIRST ? shreg_q[WIDTH-1] : shreg_q[0];
    assign sout_valid = in_shift;
    assign busy       = in_shift;

endmodule

// File: tb/tb_piso_shift_reg_param.sv
// Directed bench driving an MSB-first and an LSB-first 8-bit instance in
// lockstep from the same inputs.
module tb_piso_shift_reg_param;

    logic       clk = 1'b0;
    logic       rst;
    logic       load_valid;
    logic       shift_en;
    logic [7:0] din;

    logic load_ready_a, sout_a, sout_valid_a, busy_a, done_a;
    logic load_ready_b, sout_b, sout_valid_b, busy_b, done_b;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    piso_shift_reg_param #(
        .WIDTH     (8),
        .MSB_FIRST (1'b1)
    ) dut_a (
        .clk        (clk),
        .rst        (rst),
        .load_valid (load_valid),
        .load_ready (load_ready_a),
        .din        (din),
        .shift_en   (shift_en),
        .sout       (sout_a),
        .sout_valid (sout_valid_a),
        .busy       (busy_a),
        .done       (done_a)
    );

    piso_shift_reg_param #(
        .WIDTH     (8),
        .MSB_FIRST (1'b0)
    ) dut_b (
        .clk        (clk),
        .rst        (rst),
        .load_valid (load_valid),
        .load_ready (load_ready_b),
        .din        (din),
        .shift_en   (shift_en),
        .sout       (sout_b),
        .sout_valid (sout_valid_b),
        .busy       (busy_b),
        .done       (done_b)
    );

    task automatic chk(input string tag, input logic obs, input logic exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    endtask

    task automatic idle_chk(input string tag);
        chk({tag, "_sout_a"},       sout_a,       1'b0);
        chk({tag, "_sout_b"},       sout_b,       1'b0);
        chk({tag, "_valid_a"},      sout_valid_a, 1'b0);
        chk({tag, "_valid_b"},      sout_valid_b, 1'b0);
        chk({tag, "_busy_a"},       busy_a,       1'b0);
        chk({tag, "_done_a"},       done_a,       1'b0);
        chk({tag, "_done_b"},       done_b,       1'b0);
        chk({tag, "_ready_a"},      load_ready_a, 1'b1);
        chk({tag, "_ready_b"},      load_ready_b, 1'b1);
    endtask

    // seq_a / seq_b list the expected serial bits left to right.
    task automatic frame(input logic [7:0] word, input logic [7:0] seq_a,
                         input logic [7:0] seq_b, input string tag);
        @(negedge clk);
        load_valid = 1'b1;
        din        = word;
        shift_en   = 1'b1;
        #1 chk({tag, "_accept_ready"}, load_ready_a, 1'b1);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            load_valid = 1'b0;
            din        = ~word;
            #1;
            chk($sformatf("%s_sout_a[%0d]", tag, i), sout_a, seq_a[7-i]);
            chk($sformatf("%s_sout_b[%0d]", tag, i), sout_b, seq_b[7-i]);
            chk($sformatf("%s_done_a[%0d]", tag, i), done_a, (i == 7));
            chk($sformatf("%s_done_b[%0d]", tag, i), done_b, (i == 7));
            chk($sformatf("%s_valid[%0d]", tag, i), sout_valid_a, 1'b1);
            chk($sformatf("%s_ready[%0d]", tag, i), load_ready_a, (i == 7));
        end
        @(negedge clk);
        #1 idle_chk({tag, "_end"});
    endtask

    initial begin
        logic [7:0] gap_a;
        logic [7:0] gap_b;
        logic [7:0] c3;

        rst        = 1'b1;
        load_valid = 1'b0;
        shift_en   = 1'b0;
        din        = '0;

        // Reset with random inputs for three edges.
        repeat (3) begin
            @(negedge clk);
            rst        = 1'b1;
            load_valid = 1'($urandom);
            shift_en   = 1'($urandom);
            din        = 8'($urandom);
        end
        @(negedge clk);
        rst        = 1'b0;
        load_valid = 1'b0;
        #1 idle_chk("reset");

        frame(8'hA5, 8'b10100101, 8'b10100101, "a5");
        frame(8'h01, 8'b00000001, 8'b10000000, "h01");

        // Gapped enable 1,0,0 repeating; load_valid pulses mid-frame.
        gap_a = 8'b11110000;
        gap_b = 8'b00001111;
        @(negedge clk);
        load_valid = 1'b1;
        din        = 8'hF0;
        shift_en   = 1'b1;
        #1 chk("gap_accept_ready", load_ready_a, 1'b1);
        for (int j = 0; j < 22; j++) begin
            @(negedge clk);
            shift_en   = (j % 3 == 0);
            load_valid = (j % 3 == 1);
            din        = 8'h00;
            #1;
            chk($sformatf("gap_sout_a[%0d]", j), sout_a, gap_a[7 - (j + 2) / 3]);
            chk($sformatf("gap_sout_b[%0d]", j), sout_b, gap_b[7 - (j + 2) / 3]);
            chk($sformatf("gap_done[%0d]", j), done_a, (j == 21));
            chk($sformatf("gap_ready[%0d]", j), load_ready_a, (j == 21));
            chk($sformatf("gap_busy[%0d]", j), busy_b, 1'b1);
        end
        @(negedge clk);
        load_valid = 1'b0;
        shift_en   = 1'b1;
        #1 idle_chk("gap_end");

        // Back-to-back FF then 00 with no idle bit between frames.
        @(negedge clk);
        load_valid = 1'b1;
        din        = 8'hFF;
        shift_en   = 1'b1;
        #1 chk("b2b_accept_ready", load_ready_b, 1'b1);
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            load_valid = (i < 8);
            din        = 8'h00;
            #1;
            chk($sformatf("b2b_sout_a[%0d]", i), sout_a, (i < 8));
            chk($sformatf("b2b_sout_b[%0d]", i), sout_b, (i < 8));
            chk($sformatf("b2b_valid[%0d]", i), sout_valid_a, 1'b1);
            chk($sformatf("b2b_done_a[%0d]", i), done_a, (i == 7 || i == 15));
            chk($sformatf("b2b_done_b[%0d]", i), done_b, (i == 7 || i == 15));
            chk($sformatf("b2b_ready[%0d]", i), load_ready_a, (i == 7 || i == 15));
        end
        @(negedge clk);
        load_valid = 1'b0;
        #1 idle_chk("b2b_end");

        // Reset while bit 4 of C3 is on the line.
        c3 = 8'b11000011;
        @(negedge clk);
        load_valid = 1'b1;
        din        = 8'hC3;
        shift_en   = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            load_valid = 1'b0;
            rst        = (i == 4);
            #1;
            chk($sformatf("rstmid_sout_a[%0d]", i), sout_a, c3[7-i]);
            chk($sformatf("rstmid_sout_b[%0d]", i), sout_b, c3[7-i]);
            chk($sformatf("rstmid_done[%0d]", i), done_a, 1'b0);
        end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            rst = 1'b0;
            #1 idle_chk($sformatf("rstmid_after[%0d]", i));
        end

        frame(8'h81, 8'b10000001, 8'b10000001, "h81");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
